// File: rtl/door_pulse_encoder.sv
// Door switch front end: synchronises and debounces the raw reed switch, then emits
// one-shot I1 (opened) / I0 (closed) pulses, a debounced level and an open-too-long alarm.
module door_pulse_encoder #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int PULSE_WIDTH     = 1,
    parameter int ALARM_CYCLES    = 16,
    parameter int CNT_W           = 8
) (
    input  logic sync_clk,
    input  logic reset,
    input  logic door_raw,
    output logic I1,
    output logic I0,
    output logic door_open,
    output logic alarm
);

    typedef enum logic [1:0] {
        CLOSED,
        OPENING,
        OPEN,
        CLOSING
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_WIDTH - 1);
    localparam logic [CNT_W-1:0] ALARM_MAX  = CNT_W'(ALARM_CYCLES);
    localparam logic [CNT_W-1:0] ALARM_LAST = CNT_W'(ALARM_CYCLES - 1);

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] deb_cnt;
    logic [CNT_W-1:0] pulse_cnt;
    logic [CNT_W-1:0] alarm_cnt;

    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= door_raw;
            s2 <= s1;
        end
    end

    // Later assignments in the case statement take priority over the pulse and
    // alarm bookkeeping above it, so an accepted transition always wins.
    always_ff @(posedge sync_clk or posedge reset) begin
        if (reset) begin
            state     <= CLOSED;
            deb_cnt   <= '0;
            pulse_cnt <= '0;
            alarm_cnt <= '0;
            I1        <= 1'b0;
            I0        <= 1'b0;
            door_open <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            if (pulse_cnt != '0) begin
                pulse_cnt <= pulse_cnt - CNT_ONE;
            end else begin
                I1 <= 1'b0;
                I0 <= 1'b0;
            end

            if (state == OPEN || state == CLOSING) begin
                if (alarm_cnt != ALARM_MAX) begin
                    alarm_cnt <= alarm_cnt + CNT_ONE;
                end
                if (alarm_cnt >= ALARM_LAST) begin
                    alarm <= 1'b1;
                end
            end

            case (state)
                CLOSED: begin
                    if (s2) begin
                        state   <= OPENING;
                        deb_cnt <= CNT_ONE;
                    end
                end
                OPENING: begin
                    if (!s2) begin
                        state   <= CLOSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= OPEN;
                        deb_cnt   <= '0;
                        I1        <= 1'b1;
                        I0        <= 1'b0;
                        pulse_cnt <= PULSE_LAST;
                        door_open <= 1'b1;
                        alarm_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                OPEN: begin
                    if (!s2) begin
                        state   <= CLOSING;
                        deb_cnt <= CNT_ONE;
                    end
                end
                CLOSING: begin
                    if (s2) begin
                        state   <= OPEN;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state     <= CLOSED;
                        deb_cnt   <= '0;
                        I0        <= 1'b1;
                        I1        <= 1'b0;
                        pulse_cnt <= PULSE_LAST;
                        door_open <= 1'b0;
                        alarm     <= 1'b0;
                        alarm_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end
                default: begin
                    state <= CLOSED;
                end
            endcase
        end
    end

endmodule

// File: doc/door_pulse_encoder.md
# door_pulse_encoder

Converts the raw refrigerator door switch level into the single-event pulse pair consumed by the refrigerator controller: `I1` (door opened) and `I0` (door closed). It sits between the door reed switch and the controller's `I1`/`I0` inputs and drives them on the `sync_clk` domain. The raw switch is synchronised, debounced and tracked by a four-state FSM. An open-too-long alarm is also provided.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronised samples required to accept a level change; legal range is ≥ 2.
- `PULSE_WIDTH`, default 1: width of each `I1`/`I0` pulse in cycles. `DEBOUNCE_CYCLES ≥ PULSE_WIDTH + 1` is required.
- `ALARM_CYCLES`, default 16: cycles the door may remain open before `alarm` asserts.
- `CNT_W`, default 8: width of the internal debounce, pulse and alarm counters. It must hold `ALARM_CYCLES`.
- `sync_clk` input, 1 bit: the single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-high. Clears all state and outputs immediately.
- `door_raw` input, 1 bit: asynchronous switch level. 1 = open, 0 = closed.
- `I1` output, 1 bit: door-open pulse, registered.
- `I0` output, 1 bit: door-close pulse, registered.
- `door_open` output, 1 bit: debounced door level, registered.
- `alarm` output, 1 bit: door open for `ALARM_CYCLES` or more, registered.

## Operation
- **Synchroniser.**
  - `door_raw` passes through two flops, s1 then s2; both reset to 0.
  - The FSM uses only s2.
- **FSM states and transitions** (reset state is CLOSED):
  - CLOSED:
    - s2=1 → OPENING, with debounce count = 1.
  - OPENING:
    - s2=0 → CLOSED. No pulse is emitted; this is a glitch reject.
    - s2=1 and count = `DEBOUNCE_CYCLES`−1 → OPEN. `I1` starts, `door_open` goes to 1, and the alarm counter clears.
    - otherwise, count increments.
  - OPEN:
    - s2=0 → CLOSING, with count = 1.
  - CLOSING:
    - s2=1 → OPEN. No pulse is emitted.
    - s2=0 and count = `DEBOUNCE_CYCLES`−1 → CLOSED. `I0` starts, `door_open` goes to 0, and `alarm` goes to 0.
    - otherwise, count increments.
- **Pulse generator.**
  - On an accepted transition, the corresponding output is held at 1 for exactly `PULSE_WIDTH` cycles, then returns to 0.
  - A pulse always runs to completion, even if the FSM leaves the state it entered.
  - `I0` and `I1` are never 1 in the same cycle; the parameter constraint guarantees at least one idle cycle between opposite pulses.
- **`door_open`.** 1 in OPEN and CLOSING, 0 in CLOSED and OPENING.
- **Alarm counter.**
  - Increments every cycle while in OPEN or CLOSING.
  - Saturates at `ALARM_CYCLES`; it never wraps.
  - `alarm` = 1 once the counter reaches `ALARM_CYCLES`, and stays 1 until the accepted close.
  - A bounce from CLOSING back to OPEN neither clears the counter nor clears `alarm`.
- **Reset.**
  - Async assertion, including mid-pulse or mid-debounce, forces `I1`=`I0`=`door_open`=`alarm`=0, state CLOSED, and all counters to 0 within the same cycle.
  - If the door is physically open at reset release, it is detected normally and `I1` is emitted. This lets the controller learn the true door state.

## Timing
- **Reset values.** All outputs are 0.
- **Open latency.** Let `door_raw` be stable high before rising edge t0.
  - s1=1 after t0.
  - s2=1 after t0+1.
  - OPENING is entered at t0+2.
  - `I1` is high after edge t0+1+`DEBOUNCE_CYCLES`, i.e. t0+5 at the default, for `PULSE_WIDTH` cycles.
  - `door_open` rises on the same edge as `I1`.
- **Close latency.** Symmetric: `I0` and the fall of `door_open` occur at edge t0+1+`DEBOUNCE_CYCLES` after `door_raw` goes stably low.
- **Alarm.** Rises `ALARM_CYCLES` edges after `door_open` rises, provided no accepted close occurs first. It falls on the same edge as `I0` rises.
- **Glitches.**
  - A high glitch lasting fewer than `DEBOUNCE_CYCLES` s2 samples produces no pulse and no `door_open` change.
  - A glitch of exactly `DEBOUNCE_CYCLES` samples is accepted.
- **Throughput.** Minimum spacing between an `I1` rise and the next `I0` rise is `DEBOUNCE_CYCLES` cycles.

## Test plan
Parameters for all scenarios: `DEBOUNCE_CYCLES`=4, `PULSE_WIDTH`=1, `ALARM_CYCLES`=16.

1. **Reset and clean open.** Apply reset at t=0; release it; then hold `door_raw`=1 from before edge 10 onward.
   - All outputs are 0 during reset.
   - `I1`=1 only after edge 15.
   - `door_open`=1 from edge 15.
   - `I0` stays 0 throughout.
2. **Glitch reject.**
   - Door closed, `door_raw` high for 3 cycles then low → no `I1`, `door_open`=0 throughout.
   - Repeat with 4 cycles high → one `I1` pulse is accepted.
3. **Open then close.** Open as in scenario 1, then drive `door_raw`=0 from before edge 30.
   - `I0`=1 only after edge 35.
   - `door_open`=0 from edge 35.
   - `I0` and `I1` are never high together.
4. **Alarm.** Open the door (accepted at edge E) and keep it open.
   - `alarm`=1 from edge E+16.
   - A 2-cycle low bounce at E+20 leaves `alarm`=1 and produces no `I0`.
   - A sustained close clears `alarm` on the `I0` edge.
5. **Reset mid-operation.** Assert reset in the same cycle `I1` is high.
   - `I1`, `door_open` and `alarm` drop to 0 immediately.
   - With `door_raw` still 1 after release, `I1` re-fires 5 edges after the first post-release edge.
6. **Width sweep.** Set `PULSE_WIDTH`=3 and `DEBOUNCE_CYCLES`=4, then toggle the door as fast as legally allowed.
   - Every pulse is exactly 3 cycles wide.
   - There is at least 1 idle cycle between `I1` and `I0`.
